// File: rtl/misc.sv
// Shared definitions for the stopwatch codebase slice.
//   stopwatch_state_t  : controller states
//   DIGIT*_MAX_DEFAULT : default last value of each display digit before wrap
//   FREQUENCY_10HZ     : 50 MHz clock cycles per 10 Hz timer period
package misc;

    typedef enum logic [1:0] {
        CLEARED,
        RUNNING,
        STOPPED,
        LAP
    } stopwatch_state_t;

    localparam int unsigned DIGIT0_MAX_DEFAULT = 9;
    localparam int unsigned DIGIT1_MAX_DEFAULT = 15;
    localparam int unsigned FREQUENCY_10HZ     = 5_000_000;

endpackage

// File: rtl/digit_counter.sv
// Single wrapping display digit, counting 0..MAX.
//   clock       : system clock
//   reset_s2_n  : asynchronous active-low reset, clears the value
//   clear       : synchronous clear to 0
//   enable      : advance by one (wrap to 0 after MAX)
//   value[3:0]  : current digit value
//   carry       : combinational, high when enabled at MAX (next digit advances)
module digit_counter #(
    parameter int unsigned MAX = 9
) (
    input  logic       clock,
    input  logic       reset_s2_n,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] value,
    output logic       carry
);

    localparam logic [3:0] MAX_VALUE = 4'(MAX);

    logic at_max;

    assign at_max = (value == MAX_VALUE);
    assign carry  = enable && at_max;

    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            value <= 4'd0;
        end else if (clear) begin
            value <= 4'd0;
        end else if (enable) begin
            value <= at_max ? 4'd0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Two-digit stopwatch controller: tenths on hex0 (digit0), seconds on hex1 (digit1).
// Button 0 starts/stops, button 1 freezes a lap display while running or clears when stopped.
//   clock               : 50 MHz system clock
//   reset_s2_n          : synchronized reset, asynchronous, active-low
//   start_stop_pressed  : single-cycle pressdown pulse, button 0
//   lap_clear_pressed   : single-cycle pressdown pulse, button 1
//   tick                : single-cycle 10 Hz timer elapsed flag
//   timer_enable        : enable for the 10 Hz timer
//   digit0 / digit1     : values shown on hex0 / hex1
//   running             : high in RUNNING or LAP
//   lap_active          : high in LAP (display frozen)
//   overflow            : sticky, count wrapped from max/max to 0/0
module stopwatch_ctrl
    import misc::*;
#(
    parameter int unsigned DIGIT0_MAX = DIGIT0_MAX_DEFAULT,
    parameter int unsigned DIGIT1_MAX = DIGIT1_MAX_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_s2_n,
    input  logic       start_stop_pressed,
    input  logic       lap_clear_pressed,
    input  logic       tick,
    output logic       timer_enable,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    stopwatch_state_t state_q;
    stopwatch_state_t state_d;

    logic [3:0] count0;
    logic [3:0] count1;
    logic [3:0] lap0_q;
    logic [3:0] lap1_q;
    logic       carry0;
    logic       carry1;
    logic       count_tick;
    logic       lap_pulse;
    logic       clear_count;
    logic       lap_capture;

    // Ticks count off the registered state, so a tick coinciding with a stop pulse still counts
    // and a stale elapse after the timer is disabled is dropped.
    assign count_tick = tick && ((state_q == RUNNING) || (state_q == LAP));

    // start/stop wins over a simultaneous lap/clear pulse.
    assign lap_pulse   = lap_clear_pressed && !start_stop_pressed;
    assign clear_count = lap_pulse && (state_q == STOPPED);
    assign lap_capture = lap_pulse && (state_q == RUNNING);

    digit_counter #(
        .MAX(DIGIT0_MAX)
    ) u_tenths (
        .clock      (clock),
        .reset_s2_n (reset_s2_n),
        .clear      (clear_count),
        .enable     (count_tick),
        .value      (count0),
        .carry      (carry0)
    );

    digit_counter #(
        .MAX(DIGIT1_MAX)
    ) u_seconds (
        .clock      (clock),
        .reset_s2_n (reset_s2_n),
        .clear      (clear_count),
        .enable     (carry0),
        .value      (count1),
        .carry      (carry1)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEARED: begin
                if (start_stop_pressed) state_d = RUNNING;
            end
            RUNNING: begin
                if (start_stop_pressed) state_d = STOPPED;
                else if (lap_clear_pressed) state_d = LAP;
            end
            LAP: begin
                if (start_stop_pressed) state_d = STOPPED;
                else if (lap_clear_pressed) state_d = RUNNING;
            end
            STOPPED: begin
                if (start_stop_pressed) state_d = RUNNING;
                else if (lap_clear_pressed) state_d = CLEARED;
            end
            default: state_d = CLEARED;
        endcase
    end

    // State plus registered status outputs, lap latch and sticky overflow.
    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            state_q      <= CLEARED;
            timer_enable <= 1'b0;
            running      <= 1'b0;
            lap_active   <= 1'b0;
            overflow     <= 1'b0;
            lap0_q       <= 4'd0;
            lap1_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            timer_enable <= (state_d == RUNNING) || (state_d == LAP);
            running      <= (state_d == RUNNING) || (state_d == LAP);
            lap_active   <= (state_d == LAP);

            if (clear_count) begin
                overflow <= 1'b0;
            end else if (carry1) begin
                overflow <= 1'b1;
            end

            // Captures the pre-increment count when a tick lands on the lap pulse.
            if (lap_capture) begin
                lap0_q <= count0;
                lap1_q <= count1;
            end
        end
    end

    // Selects between flops only; lap_active mirrors state_q == LAP.
    assign digit0 = lap_active ? lap0_q : count0;
    assign digit1 = lap_active ? lap1_q : count1;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl against an integer-count behavioural model.
module tb_stopwatch_ctrl;

    localparam int D0  = 9;
    localparam int D1  = 15;
    localparam int MOD = (D0 + 1) * (D1 + 1);

    localparam int M_CLR  = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;
    localparam int M_LAP  = 3;

    logic       clock = 1'b0;
    logic       reset_s2_n = 1'b0;
    logic       start_stop_pressed = 1'b0;
    logic       lap_clear_pressed = 1'b0;
    logic       tick = 1'b0;
    logic       timer_enable;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic       running;
    logic       lap_active;
    logic       overflow;

    logic [11:0] obs;
    logic [11:0] exp_v;

    int checks = 0;
    int fails  = 0;

    // Model: elapsed tenths as a plain integer modulo the display range.
    int m_state = M_CLR;
    int m_count = 0;
    int m_lap   = 0;
    bit m_ovf   = 1'b0;

    stopwatch_ctrl #(
        .DIGIT0_MAX(D0),
        .DIGIT1_MAX(D1)
    ) dut (
        .clock              (clock),
        .reset_s2_n         (reset_s2_n),
        .start_stop_pressed (start_stop_pressed),
        .lap_clear_pressed  (lap_clear_pressed),
        .tick               (tick),
        .timer_enable       (timer_enable),
        .digit0             (digit0),
        .digit1             (digit1),
        .running            (running),
        .lap_active         (lap_active),
        .overflow           (overflow)
    );

    always #10 clock = ~clock;

    assign obs = {timer_enable, running, lap_active, overflow, digit1, digit0};

    function automatic logic [11:0] expected();
        int  disp;
        bit  act;
        disp = (m_state == M_LAP) ? m_lap : m_count;
        act  = (m_state == M_RUN) || (m_state == M_LAP);
        return {act, act, (m_state == M_LAP), m_ovf,
                4'(disp / (D0 + 1)), 4'(disp % (D0 + 1))};
    endfunction

    task automatic model_reset();
        m_state = M_CLR;
        m_count = 0;
        m_lap   = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit l, input bit t);
        int old_count;
        old_count = m_count;
        if (t && (m_state == M_RUN || m_state == M_LAP)) begin
            m_count = m_count + 1;
            if (m_count == MOD) begin
                m_count = 0;
                m_ovf   = 1'b1;
            end
        end
        if (s) begin
            case (m_state)
                M_CLR:   m_state = M_RUN;
                M_RUN:   m_state = M_STOP;
                M_LAP:   m_state = M_STOP;
                default: m_state = M_RUN;
            endcase
        end else if (l) begin
            case (m_state)
                M_RUN: begin
                    m_state = M_LAP;
                    m_lap   = old_count;
                end
                M_LAP:  m_state = M_RUN;
                M_STOP: begin
                    m_state = M_CLR;
                    m_count = 0;
                    m_ovf   = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    // One clock with the given pulses; returns 1 time unit after the edge.
    task automatic cycle(input bit s, input bit l, input bit t);
        @(negedge clock);
        start_stop_pressed = s;
        lap_clear_pressed  = l;
        tick               = t;
        @(posedge clock);
        model_step(s, l, t);
        #1;
        start_stop_pressed = 1'b0;
        lap_clear_pressed  = 1'b0;
        tick               = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_s2_n = 1'b0;
        model_reset();
        @(negedge clock);
        reset_s2_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (obs !== 12'h000) begin
            fails++;
            $display("FAIL reset_state: got %h want %h", obs, 12'h000);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            exp_v = expected();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL idle_ticks cyc %0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_start();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (timer_enable !== 1'b1 || running !== 1'b1) begin
            fails++;
            $display("FAIL start_enable: got te=%b run=%b want 1 1", timer_enable, running);
        end
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b1);
            exp_v = expected();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL start_count tick %0d: got %h want %h", i, obs, exp_v);
            end
        end
        checks++;
        if ({digit1, digit0} !== 8'h12) begin
            fails++;
            $display("FAIL start_12_ticks: got %h want %h", {digit1, digit0}, 8'h12);
        end
    endtask

    task automatic test_lap();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            exp_v = expected();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL lap_frozen tick %0d: got %h want %h", i, obs, exp_v);
            end
        end
        checks++;
        if ({lap_active, digit1, digit0} !== 9'h105) begin
            fails++;
            $display("FAIL lap_hold: got %h want %h", {lap_active, digit1, digit0}, 9'h105);
        end
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({lap_active, digit1, digit0} !== 9'h012) begin
            fails++;
            $display("FAIL lap_release: got %h want %h", {lap_active, digit1, digit0}, 9'h012);
        end
        // Lap pulse coinciding with a tick latches the pre-increment count.
        cycle(1'b0, 1'b1, 1'b1);
        exp_v = expected();
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL lap_with_tick: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_stop_tick();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (7) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        checks++;
        if ({timer_enable, digit1, digit0} !== 9'h008) begin
            fails++;
            $display("FAIL stop_with_tick: got %h want %h", {timer_enable, digit1, digit0}, 9'h008);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            exp_v = expected();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL stopped_ignore %0d: got %h want %h", i, obs, exp_v);
            end
        end
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== 12'h000) begin
            fails++;
            $display("FAIL stop_clear: got %h want %h", obs, 12'h000);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (MOD - 1) cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if ({overflow, digit1, digit0} !== 9'h0F9) begin
            fails++;
            $display("FAIL ovf_at_max: got %h want %h", {overflow, digit1, digit0}, 9'h0F9);
        end
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if ({overflow, digit1, digit0} !== 9'h100) begin
            fails++;
            $display("FAIL ovf_wrap: got %h want %h", {overflow, digit1, digit0}, 9'h100);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            exp_v = expected();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL ovf_sticky %0d: got %h want %h", i, obs, exp_v);
            end
        end
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== 12'h000) begin
            fails++;
            $display("FAIL ovf_clear: got %h want %h", obs, 12'h000);
        end
    endtask

    task automatic test_simultaneous_and_async_reset();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== 12'h003) begin
            fails++;
            $display("FAIL simul_pulses: got %h want %h", obs, 12'h003);
        end
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        exp_v = expected();
        checks++;
        if (obs !== exp_v || lap_active !== 1'b1) begin
            fails++;
            $display("FAIL enter_lap: got %h want %h", obs, exp_v);
        end
        #4;
        reset_s2_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 12'h000) begin
            fails++;
            $display("FAIL async_reset: got %h want %h", obs, 12'h000);
        end
        @(negedge clock);
        reset_s2_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 1)));
            exp_v = expected();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_lap();
        test_stop_tick();
        test_overflow();
        test_simultaneous_and_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Controller that sequences one 10 Hz timer and two display digits as a two-digit stopwatch, with tenths on hex0 and seconds on hex1.
- Input pulses come from the meta_prev pressdown detector.
- Timer ticks come from timer elapsed flags; the block drives the timer enable.
- Digit values go to the two display instances.
- Provides start/stop, lap-freeze and clear functions via two buttons.

Parameters:
DIGIT0_MAX, 9, last value of digit0 (tenths) before wrap, range 1..15
DIGIT1_MAX, 15, last value of digit1 (seconds) before wrap, range 1..15

Ports:
clock  input  1  50 MHz system clock
reset_s2_n  input  1  synchronized reset, asynchronous, active-low
start_stop_pressed  input  1  single-cycle pressdown pulse, button 0
lap_clear_pressed  input  1  single-cycle pressdown pulse, button 1
tick  input  1  single-cycle timer elapsed flag (10 Hz timer)
timer_enable  output  1  enable for the 10 Hz timer
digit0  output  4  value shown on hex0
digit1  output  4  value shown on hex1
running  output  1  high in RUNNING or LAP
lap_active  output  1  high in LAP (display frozen)
overflow  output  1  sticky: count wrapped from max/max to 0/0

Behaviour:
- Reset (asynchronous, reset_s2_n low):
  - state = CLEARED.
  - count0 = count1 = 0; the lap latch is cleared.
  - All outputs are 0.
- All outputs are registered. A state transition is visible on running/lap_active/timer_enable the cycle after the input pulse.
- FSM states, with transitions evaluated on posedge clock:
  - CLEARED: timer off, count = 0. start_stop_pressed -> RUNNING. lap_clear_pressed is ignored.
  - RUNNING: timer on, display live. start_stop_pressed -> STOPPED. lap_clear_pressed -> LAP, latching the current count into the lap registers.
  - LAP: timer on, counting continues, display shows the latched count. lap_clear_pressed -> RUNNING (display live again). start_stop_pressed -> STOPPED (display live).
  - STOPPED: timer off, count held. start_stop_pressed -> RUNNING (resume). lap_clear_pressed -> CLEARED, clearing count0, count1 and overflow.
- Simultaneous pulses: start_stop_pressed has priority and lap_clear_pressed is dropped that cycle.
- Tick handling:
  - tick is honoured only when the registered state is RUNNING or LAP. This includes the cycle in which a stop pulse arrives, so that tick is counted.
  - tick in CLEARED or STOPPED is ignored (covers a stale elapse after disable).
- Counting:
  - On an honoured tick: if count0 < DIGIT0_MAX, count0 + 1. Otherwise count0 = 0 and a carry goes to count1.
  - On carry: if count1 < DIGIT1_MAX, count1 + 1. Otherwise count1 = 0 and overflow is set.
  - digit0/digit1 update one cycle after the tick (live mode).
- overflow stays set until CLEARED entry or reset. Counting continues after wrap.
- Output select:
  - digit0/digit1 = lap registers in LAP, else live count.
  - The lap latch captures the live count value present in the cycle of the lap pulse. If a tick arrives the same cycle, the latch holds the pre-increment value.
- timer_enable = 1 exactly when the registered state is RUNNING or LAP.
- Reset mid-operation (any state) returns to CLEARED immediately, with no pending state retained.

Decomposition:
- Package misc:
  - stopwatch_state_t enum {CLEARED, RUNNING, STOPPED, LAP}.
  - DIGIT0_MAX_DEFAULT = 9 and DIGIT1_MAX_DEFAULT = 15.
  - The existing FREQUENCY_10HZ is used by the parent when instantiating the timer.
- Sub-module digit_counter:
  - Parameter MAX.
  - Ports: clock, reset_s2_n, clear, enable, value[3:0], carry.
  - carry is combinational (enable && value == MAX).
  - Instantiated twice, with carry of digit0 as enable of digit1.
- The FSM, lap latch, output mux and overflow flag live in stopwatch_ctrl.

Test Plan:
- Reset then idle 20 cycles; inject tick pulses -> digit0 = digit1 = 0, timer_enable = 0, running = 0, overflow = 0.
- start pulse; 12 ticks -> timer_enable high one cycle after the pulse; after the 12th tick, digit1 = 1 and digit0 = 2.
- Running at 0/5: lap pulse; 7 more ticks -> display frozen at 0/5, lap_active = 1. Second lap pulse -> display 1/2, lap_active = 0.
- Running: stop pulse and tick in the same cycle -> tick counted, timer_enable = 0 next cycle. Later ticks are ignored. lap_clear -> 0/0 and state CLEARED.
- Running at 15/9; one tick -> 0/0, overflow = 1 and stays 1 through further ticks. Stop, then clear -> overflow = 0.
- Running: start and lap pulses in the same cycle -> STOPPED, lap_active = 0. Assert reset_s2_n low while in LAP -> all outputs 0 asynchronously, before the next clock edge.
